// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : 8N1 UART transmitter with a small byte FIFO in front of the
//             serialiser. Bytes are queued with a valid/ready handshake and
//             sent LSB first. Frames run back to back while the FIFO holds data.
//  Revision : 1.0 - initial release
//
//  Ports
//    osc_clk        in   1  single clock, rising edge
//    rst            in   1  asynchronous active-high reset
//    i_Tx_DV        in   1  byte-valid strobe (accepted when o_Tx_Ready=1)
//    i_Tx_Byte      in   8  byte to queue, sampled on acceptance
//    o_Tx_Ready     out  1  FIFO not full
//    o_Tx_Serial    out  1  serial line, idle high, registered
//    o_Tx_Active    out  1  transmitter busy (FSM not idle)
//    o_Tx_Done      out  1  one-cycle pulse in the last cycle of each frame
//    o_Tx_Overflow  out  1  one-cycle pulse after a write to a full FIFO
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       osc_clk,
  input  logic       rst,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done,
  output logic       o_Tx_Overflow
);

  localparam int              ADDR_W   = $clog2(FIFO_DEPTH);
  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]     BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Transmit FIFO
  // --------------------------------------------------------------------------
  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  // Ready looks only at the registered count, so a pop on the same edge
  // never lets a full FIFO take a write.
  assign o_Tx_Ready = (count != FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = i_Tx_DV & o_Tx_Ready;

  always_ff @(posedge osc_clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      o_Tx_Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      o_Tx_Overflow <= i_Tx_DV & ~o_Tx_Ready;
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge osc_clk) begin
    if (push) mem[wr_ptr] <= i_Tx_Byte;
  end

  // --------------------------------------------------------------------------
  // Serialiser FSM
  // --------------------------------------------------------------------------
  state_t      state, state_d;
  logic [15:0] timer, timer_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shift;
  logic        serial_d;
  logic        bit_end;

  assign bit_end     = (timer == BIT_LAST);
  assign o_Tx_Active = (state != IDLE);
  assign o_Tx_Done   = (state == STOP) && bit_end;

  always_ff @(posedge osc_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_Tx_Serial <= 1'b1;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      bit_idx     <= bit_idx_d;
      o_Tx_Serial <= serial_d;
      if (pop) shift <= mem[rd_ptr];
    end
  end

  // The line register is loaded with the level of the state being entered,
  // which is what gives the one-edge latency from pop to start bit.
  always_comb begin
    state_d   = state;
    timer_d   = timer + 16'd1;
    bit_idx_d = bit_idx;
    serial_d  = o_Tx_Serial;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        timer_d  = '0;
        serial_d = 1'b1;
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_d  = START;
          serial_d = 1'b0;
        end
      end
      START: begin
        serial_d = 1'b0;
        if (bit_end) begin
          state_d   = DATA;
          timer_d   = '0;
          bit_idx_d = 3'd0;
          serial_d  = shift[0];
        end
      end
      DATA: begin
        serial_d = shift[bit_idx];
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            serial_d  = shift[bit_idx_d];
          end
        end
      end
      STOP: begin
        serial_d = 1'b1;
        if (bit_end) begin
          timer_d = '0;
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_d  = START;
            serial_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        timer_d  = '0;
        serial_d = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Directed self-checking bench for uart_tx. Instance A runs at
//             87 clocks per bit, instance B at 4 clocks per bit with a
//             4-entry FIFO. Output traces are recorded cycle by cycle and
//             compared with frames computed from the queued bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  logic       clk;
  logic       rst;

  logic       a_dv, a_ready, a_serial, a_active, a_done, a_ovf;
  logic [7:0] a_byte;
  logic       b_dv, b_ready, b_serial, b_active, b_done, b_ovf;
  logic [7:0] b_byte;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(.CLKS_PER_BIT(87), .FIFO_DEPTH(4)) dut_a (
    .osc_clk(clk), .rst(rst), .i_Tx_DV(a_dv), .i_Tx_Byte(a_byte),
    .o_Tx_Ready(a_ready), .o_Tx_Serial(a_serial), .o_Tx_Active(a_active),
    .o_Tx_Done(a_done), .o_Tx_Overflow(a_ovf)
  );

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_b (
    .osc_clk(clk), .rst(rst), .i_Tx_DV(b_dv), .i_Tx_Byte(b_byte),
    .o_Tx_Ready(b_ready), .o_Tx_Serial(b_serial), .o_Tx_Active(b_active),
    .o_Tx_Done(b_done), .o_Tx_Overflow(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Recorded trace: index k holds outputs sampled 1 time unit after the
  // k-th rising edge following the start of recording.
  logic tr_ser [0:1023];
  logic tr_done[0:1023];
  logic tr_act [0:1023];
  logic tr_rdy [0:1023];
  logic tr_ovf [0:1023];

  logic [7:0] exp_bytes [0:7];
  int         exp_n;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic record(input int which, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      tr_ser[k]  = (which == 0) ? a_serial : b_serial;
      tr_done[k] = (which == 0) ? a_done   : b_done;
      tr_act[k]  = (which == 0) ? a_active : b_active;
      tr_rdy[k]  = (which == 0) ? a_ready  : b_ready;
      tr_ovf[k]  = (which == 0) ? a_ovf    : b_ovf;
    end
  endtask

  // Line level at offset j of a frame carrying b.
  function automatic logic exp_line(input logic [7:0] b, input int j, input int cpb);
    int s;
    s = j / cpb;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    return 1'b1;
  endfunction

  // Compare a trace against exp_n back-to-back frames starting at index start.
  task automatic check_trace(input string tag, input int start, input int cpb, input int len);
    int es, ed, ea, j, flen;
    logic xs, xd, xa, inside_f;
    es = 0; ed = 0; ea = 0;
    flen = 10 * cpb;
    for (int k = 0; k < len; k++) begin
      j = k - start;
      inside_f = (j >= 0) && (j < exp_n * flen);
      xs = inside_f ? exp_line(exp_bytes[j / flen], j % flen, cpb) : 1'b1;
      xd = inside_f && ((j % flen) == flen - 1);
      xa = inside_f;
      if (tr_ser[k]  !== xs) es++;
      if (tr_done[k] !== xd) ed++;
      if (tr_act[k]  !== xa) ea++;
    end
    check_eq({tag, "_serial_errs"}, es, 0);
    check_eq({tag, "_done_errs"},   ed, 0);
    check_eq({tag, "_active_errs"}, ea, 0);
  endtask

  function automatic int count_ovf(input int len);
    int c;
    c = 0;
    for (int k = 0; k < len; k++) if (tr_ovf[k] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    rst = 1'b1;
    a_dv = 1'b0; a_byte = 8'h00;
    b_dv = 1'b0; b_byte = 8'h00;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_serial", a_serial, 1);
    check_eq("rst_a_ready",  a_ready,  1);
    check_eq("rst_a_active", a_active, 0);
    check_eq("rst_a_done",   a_done,   0);
    check_eq("rst_a_ovf",    a_ovf,    0);
    check_eq("rst_b_serial", b_serial, 1);
    check_eq("rst_b_ready",  b_ready,  1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ---------------- 0x55 at 87 clocks/bit ----------------
    a_dv = 1'b1; a_byte = 8'h55;
    fork
      record(0, 875);
      begin
        @(posedge clk);
        #1;
        a_dv = 1'b0; a_byte = 8'hAA;
      end
    join
    check_eq("lat_idle_after_accept", tr_ser[0], 1);
    check_eq("lat_low_next_edge",     tr_ser[1], 0);
    exp_bytes[0] = 8'h55; exp_n = 1;
    check_trace("f55", 1, 87, 875);
    check_eq("f55_ovf_pulses", count_ovf(875), 0);

    // ---------------- 4 back-to-back frames ----------------
    exp_bytes[0] = 8'h01; exp_bytes[1] = 8'h80;
    exp_bytes[2] = 8'hFF; exp_bytes[3] = 8'h00; exp_n = 4;
    fork
      record(1, 165);
      begin
        for (int i = 0; i < 4; i++) begin
          b_byte = exp_bytes[i]; b_dv = 1'b1;
          @(posedge clk);
          #1;
        end
        b_dv = 1'b0; b_byte = 8'hEE;
      end
    join
    check_eq("b2b_ovf_pulses", count_ovf(165), 0);
    check_trace("b2b", 1, 4, 165);

    // ---------------- overflow: 6 writes while busy ----------------
    fork
      record(1, 205);
      begin
        b_byte = 8'h11; b_dv = 1'b1;
        @(posedge clk); #1;
        b_dv = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 6; i++) begin
          b_byte = 8'h21 + 8'(i); b_dv = 1'b1;
          @(posedge clk); #1;
        end
        b_dv = 1'b0; b_byte = 8'hEE;
      end
    join
    check_eq("ovf_ready_before_full", tr_rdy[6], 1);
    check_eq("ovf_ready_full",        tr_rdy[7], 0);
    check_eq("ovf_ready_held",        tr_rdy[40], 0);
    check_eq("ovf_ready_after_pop",   tr_rdy[41], 1);
    check_eq("ovf_pulse_1",           tr_ovf[8], 1);
    check_eq("ovf_pulse_2",           tr_ovf[9], 1);
    check_eq("ovf_pulse_count",       count_ovf(205), 2);
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h21; exp_bytes[2] = 8'h22;
    exp_bytes[3] = 8'h23; exp_bytes[4] = 8'h24; exp_n = 5;
    check_trace("ovf", 1, 4, 205);

    // ---------------- write on the pop edge with DEPTH-1 queued ----------------
    fork
      record(1, 245);
      begin
        b_byte = 8'h11; b_dv = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
          b_byte = 8'h31 + 8'(i);
          @(posedge clk); #1;
        end
        b_dv = 1'b0; b_byte = 8'hEE;
        repeat (37) begin @(posedge clk); #1; end
        b_byte = 8'h34; b_dv = 1'b1;      // lands on the end-of-frame pop edge
        @(posedge clk); #1;
        b_byte = 8'h35;                    // fills the FIFO only if count stayed 3
        @(posedge clk); #1;
        b_dv = 1'b0; b_byte = 8'hEE;
      end
    join
    check_eq("pop_wr_ready_before", tr_rdy[40], 1);
    check_eq("pop_wr_ready_after",  tr_rdy[41], 1);
    check_eq("pop_wr_ready_full",   tr_rdy[42], 0);
    check_eq("pop_wr_ovf_pulses",   count_ovf(245), 0);
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h31; exp_bytes[2] = 8'h32;
    exp_bytes[3] = 8'h33; exp_bytes[4] = 8'h34; exp_bytes[5] = 8'h35; exp_n = 6;
    check_trace("pop_wr", 1, 4, 245);

    // ---------------- reset during DATA bit 3 of 0xA5 ----------------
    b_byte = 8'hA5; b_dv = 1'b1;
    @(posedge clk); #1;
    b_byte = 8'hB1;
    @(posedge clk); #1;
    b_byte = 8'hB2;
    @(posedge clk); #1;
    b_dv = 1'b0; b_byte = 8'hEE;
    repeat (16) begin @(posedge clk); #1; end
    check_eq("rstmid_in_bit3", b_serial, 0);   // bit 3 of 0xA5 is 0
    check_eq("rstmid_active",  b_active, 1);
    rst = 1'b1;
    #1;
    check_eq("rstmid_line_high", b_serial, 1);
    check_eq("rstmid_ready",     b_ready,  1);
    check_eq("rstmid_inactive",  b_active, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    record(1, 200);
    exp_n = 0;
    check_trace("post_rst", 0, 4, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
